// File: rtl/io_bus_responder.sv
// Memory-mapped IO responder: two scratch registers, a free-running cycle
// counter, and a byte TX FIFO feeding a downstream serializer.
module io_bus_responder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_write_en,
  input  logic        io_read_en,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [5:0] W_SCRATCH0 = 6'h00;
  localparam logic [5:0] W_SCRATCH1 = 6'h01;
  localparam logic [5:0] W_CYCLES   = 6'h02;
  localparam logic [5:0] W_TXDATA   = 6'h03;
  localparam logic [5:0] W_STATUS   = 6'h04;

  logic [31:0]      scratch0_q, scratch0_d;
  logic [31:0]      scratch1_q, scratch1_d;
  logic [31:0]      cycles_q, cycles_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       mem [FIFO_DEPTH];

  logic [5:0]  word;
  logic        empty, full, push, pop, tx_wr;
  logic [31:0] count_ext, status;

  assign word      = io_address[7:2];
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign tx_wr     = io_write_en && (word == W_TXDATA);
  // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign push      = tx_wr && !full;
  assign pop       = !empty && tx_ready;
  assign count_ext = 32'(count_q);
  assign status    = {24'h0, count_ext[3:0], 1'b0, ovf_q, full, empty};

  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : mem[rd_ptr_q];

  always_comb begin
    scratch0_d = scratch0_q;
    scratch1_d = scratch1_q;
    cycles_d   = cycles_q + 32'd1;
    ovf_d      = ovf_q;
    rdata_d    = rdata_q;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

    if (tx_wr && full) ovf_d = 1'b1;

    if (io_write_en) begin
      case (word)
        W_SCRATCH0: scratch0_d = io_write_data;
        W_SCRATCH1: scratch1_d = io_write_data;
        W_CYCLES:   cycles_d   = io_write_data;
        W_STATUS:   if (io_write_data[2]) ovf_d = 1'b0;
        default:    ;
      endcase
    end

    // Reads see register state from the start of the cycle, before any write.
    if (io_read_en) begin
      case (word)
        W_SCRATCH0: rdata_d = scratch0_q;
        W_SCRATCH1: rdata_d = scratch1_q;
        W_CYCLES:   rdata_d = cycles_q;
        W_STATUS:   rdata_d = status;
        default:    rdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scratch0_q <= '0;
      scratch1_q <= '0;
      cycles_q   <= '0;
      rdata_q    <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      scratch0_q <= scratch0_d;
      scratch1_q <= scratch1_d;
      cycles_q   <= cycles_d;
      rdata_q    <= rdata_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is not reset; tx_data is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= io_write_data[7:0];
  end

  assign io_read_data = rdata_q;

endmodule

// File: tb/tb_io_bus_responder.sv
// Randomized scoreboard bench for io_bus_responder against a queue-based
// reference model of the register map and TX FIFO.
module tb_io_bus_responder;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, re, tx_ready;
  logic [31:0] addr, wd, rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  io_bus_responder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .io_write_en(we), .io_read_en(re),
    .io_address(addr), .io_write_data(wd), .io_read_data(rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] rd_exp[$];
  logic [7:0]  tx_exp[$];
  logic [7:0]  mfifo[$];
  logic [31:0] m_s0, m_s1, cyc_base_val;
  logic        m_ovf;
  int          cyc_base_k, tnow;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] m_read(logic [5:0] w);
    case (w)
      6'h00: return m_s0;
      6'h01: return m_s1;
      6'h02: return cyc_base_val + 32'(tnow - cyc_base_k);
      6'h04: return {24'h0, 4'(mfifo.size()), 1'b0, m_ovf,
                     (mfifo.size() == DEPTH), (mfifo.size() == 0)};
      default: return 32'h0;
    endcase
  endfunction

  // One bus cycle: drive inputs, advance the model, then check after the edge.
  task automatic cyc(input logic w, input logic r, input logic [31:0] a,
                     input logic [31:0] d, input logic rdy);
    logic full;
    logic [7:0] tmp;
    we = w; re = r; addr = a; wd = d; tx_ready = rdy;
    if (r) rd_exp.push_back(m_read(a[7:2]));
    full = (mfifo.size() == DEPTH);
    if (rdy && mfifo.size() != 0) tmp = mfifo.pop_front();
    if (w) begin
      case (a[7:2])
        6'h00: m_s0 = d;
        6'h01: m_s1 = d;
        6'h02: begin cyc_base_val = d; cyc_base_k = tnow + 1; end
        6'h03: if (full) m_ovf = 1'b1;
               else begin mfifo.push_back(d[7:0]); tx_exp.push_back(d[7:0]); end
        6'h04: if (d[2]) m_ovf = 1'b0;
        default: ;
      endcase
    end
    @(posedge clk); #1;
    tnow++;
    we = 1'b0; re = 1'b0;
    check("tx_valid", {31'h0, tx_valid}, {31'h0, mfifo.size() != 0});
    if (mfifo.size() == 0) check("tx_data_empty", {24'h0, tx_data}, 32'h0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tnow++;
    mfifo.delete(); tx_exp.delete();
    m_s0 = '0; m_s1 = '0; m_ovf = 1'b0;
    cyc_base_val = '0; cyc_base_k = tnow;
    check("tx_valid_rst", {31'h0, tx_valid}, 32'h0);
    check("tx_data_rst", {24'h0, tx_data}, 32'h0);
    check("rdata_rst", rdata, 32'h0);
  endtask

  // Read monitor: a read sampled at an edge is compared at the following negedge.
  initial begin
    logic pend;
    forever begin
      @(posedge clk);
      pend = re && !reset;
      @(negedge clk);
      if (pend) begin
        if (rd_exp.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_data unexpected actual=%h expected=none", rdata);
        end else check("rd_data", rdata, rd_exp.pop_front());
      end
    end
  end

  // TX monitor: a handshake about to happen on the next edge consumes one byte.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && tx_valid && tx_ready) begin
        if (tx_exp.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_byte unexpected actual=%h expected=none", tx_data);
        end else check("tx_byte", {24'h0, tx_data}, {24'h0, tx_exp.pop_front()});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    reset = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wd = '0; tx_ready = 1'b0;
    m_s0 = '0; m_s1 = '0; m_ovf = 1'b0; tnow = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc_base_val = '0; cyc_base_k = 0;
    check("rdata_init", rdata, 32'h0);
    check("tx_valid_init", {31'h0, tx_valid}, 32'h0);
    check("tx_data_init", {24'h0, tx_data}, 32'h0);

    cyc(0, 1, 32'h00, 0, 0);
    cyc(0, 1, 32'h04, 0, 0);
    cyc(0, 1, 32'h08, 0, 0);
    cyc(0, 1, 32'h0C, 0, 0);
    cyc(0, 1, 32'h10, 0, 0);

    // Aliasing through ignored address bits
    cyc(1, 0, 32'h04, 32'hDEADBEEF, 0);
    cyc(0, 1, 32'h04, 0, 0);
    cyc(0, 1, 32'h104, 0, 0);

    // Counter load and wrap
    cyc(1, 0, 32'h08, 32'hFFFFFFFE, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 32'h08, 0, 0);

    // Overflow on the ninth push, then drain in order
    for (int i = 1; i <= 9; i++) cyc(1, 0, 32'h0C, i, 0);
    cyc(0, 1, 32'h10, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 32'h10, 32'h4, 0);

    // Push into full FIFO during a pop is dropped
    for (int i = 1; i <= 8; i++) cyc(1, 0, 32'h0C, 32'h10 + i, 0);
    cyc(1, 0, 32'h0C, 32'hAA, 1);
    cyc(0, 1, 32'h10, 0, 0);

    // Clear overflow and drain
    cyc(1, 0, 32'h10, 32'h4, 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 32'h10, 0, 0);

    // Simultaneous read and write returns the old value
    cyc(1, 1, 32'h00, 32'h12345678, 0);
    cyc(0, 1, 32'h00, 0, 0);
    cyc(1, 1, 32'h08, 32'h55, 0);
    cyc(0, 1, 32'h08, 0, 0);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) cyc(1, 0, 32'h0C, 32'hC0 + i, 0);
    cyc(0, 0, 0, 0, 1);
    do_reset();
    cyc(0, 1, 32'h10, 0, 0);
    cyc(0, 1, 32'h20, 0, 0);
    cyc(0, 1, 32'h00, 0, 0);

    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else begin
        case ($urandom_range(0, 8))
          0: a = 32'h00;
          1: a = 32'h04;
          2: a = 32'h08;
          3, 4, 5: a = 32'h0C;
          6: a = 32'h10;
          7: a = 32'h20;
          default: a = $urandom;
        endcase
        a = a | ($urandom & 32'hFFFFFF03);
        cyc(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)), a,
            $urandom, 1'($urandom_range(0, 99) < 40));
      end
    end

    for (int i = 0; i < DEPTH + 4; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    check("rd_queue_drained", rd_exp.size(), 32'h0);
    check("tx_queue_drained", tx_exp.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_bus_responder.md
IO_BUS_RESPONDER -- requirements
Module: io_bus_responder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, giving the TX FIFO depth in entries; the value SHALL be a power of two, at least 2.
REQ-002 The block SHALL have input clk, 1 bit, the clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have input reset, 1 bit, an asynchronous, active-high reset.
REQ-004 The block SHALL have input io_write_en, 1 bit, a single-cycle write strobe from the core.
REQ-005 The block SHALL have input io_read_en, 1 bit, a single-cycle read strobe from the core.
REQ-006 The block SHALL have input io_address, 32 bits, the byte address; it SHALL decode bits [7:2] only and ignore bits [31:8] and [1:0].
REQ-007 The block SHALL have input io_write_data, 32 bits, the write payload.
REQ-008 The block SHALL have output io_read_data, 32 bits, the registered read response.
REQ-009 The block SHALL have output tx_valid, 1 bit, asserted when the TX FIFO holds data.
REQ-010 The block SHALL have output tx_data, 8 bits, the TX FIFO head entry.
REQ-011 The block SHALL have input tx_ready, 1 bit, asserted when the downstream serializer accepts a byte.

Function
REQ-012 Register map (offset = io_address[7:0]):
- 0x00: SCRATCH0, 32-bit read/write.
- 0x04: SCRATCH1, 32-bit read/write.
- 0x08: CYCLES, 32-bit; a write loads io_write_data.
- 0x0C: TXDATA, write-only; reads return 0.
- 0x10: STATUS.
- All other offsets: reads return 0, writes are ignored.
REQ-013 STATUS layout SHALL be:
- bit0: empty.
- bit1: full.
- bit2: overflow, sticky.
- bits[7:4]: count.
- bits[31:8]: 0.
REQ-014 A write to STATUS with io_write_data[2]=1 SHALL clear overflow; all other STATUS bits SHALL ignore writes.
REQ-015 Read latency SHALL be 1 cycle:
- io_read_data SHALL be updated on the edge after io_read_en.
- io_read_data SHALL hold its value until the next read.
REQ-016 CYCLES SHALL increment by 1 every cycle and wrap from 0xFFFFFFFF to 0.
REQ-017 On a cycle with a CYCLES write, the next value SHALL be io_write_data, not io_write_data+1.
REQ-018 A TXDATA write SHALL push io_write_data[7:0] into the FIFO when count < FIFO_DEPTH at the start of that cycle.
REQ-019 A TXDATA write when count == FIFO_DEPTH SHALL set overflow, SHALL drop the byte, and SHALL leave the FIFO unchanged, even if a pop occurs in the same cycle.
REQ-020 A pop SHALL occur when tx_valid && tx_ready; tx_data SHALL then advance to the next entry on the following edge.
REQ-021 tx_valid SHALL equal (count != 0).
REQ-022 tx_data SHALL be stable while tx_valid && !tx_ready.
REQ-023 A simultaneous push and pop with 0 < count < FIFO_DEPTH SHALL leave count unchanged.
REQ-024 A push with count == 0 SHALL raise tx_valid on the next cycle; tx_data SHALL never be combinationally forwarded from io_write_data.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-026 When io_read_en and io_write_en are both asserted in one cycle:
- Both operations SHALL be performed.
- The read SHALL return the pre-write register value.
REQ-027 A read of STATUS SHALL reflect state at the start of the read cycle.

Reset
REQ-028 While reset is high, the block SHALL force:
- SCRATCH0, SCRATCH1, CYCLES and io_read_data to 0.
- FIFO pointers and count to 0, and overflow to 0.
- tx_valid to 0.
REQ-029 Reset asserted mid-operation SHALL discard all FIFO contents immediately; no tx_valid SHALL be presented after reset deasserts until a new push.
REQ-030 tx_data SHALL be 0 while the FIFO is empty after reset.

Verification
REQ-031 Write SCRATCH1=0xDEADBEEF, then read 0x04, then read 0x104 -> io_read_data = 0xDEADBEEF one cycle after each read (aliasing via ignored bits [31:8]).
REQ-032 Write CYCLES=0xFFFFFFFE, then read 2 cycles later -> 0x00000000 (wrap).
REQ-033 With tx_ready=0, push 9 bytes 0x01..0x09 -> STATUS = 0x86 (count 8, full, overflow); then tx_ready=1 -> 0x01..0x08 emitted in order, one per cycle, and the 0x09 byte is dropped.
REQ-034 With FIFO full and tx_ready=1, push 0xAA in the same cycle as a pop -> byte dropped, overflow=1, count=7 next cycle.
REQ-035 Write STATUS=0x4 -> overflow cleared, STATUS = 0x01 when empty.
REQ-036 Push 3 bytes, assert reset for one cycle mid-drain -> tx_valid=0 after reset; STATUS = 0x01; unmapped offset 0x20 reads 0.
